key_conditioner: RTL

Input-conditioning stage between the DE1-SoC push-buttons (`key`, raw, active-low, asynchronous, bouncing) and the `DE1_SoC` core logic. For each key it synchronises the raw input into the `clock_50` domain and debounces it with a per-key stability counter. It then outputs a clean active-high pressed level plus one-cycle press and release pulses. The core consumes these outputs instead of the raw `key` pins.

---
 rtl/key_conditioner_pkg.sv | 16 +
 rtl/key_debounce_cell.sv | 56 +++++
 rtl/key_conditioner.sv | 30 +++
 3 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared constants for the push-button conditioning stage.
// Also provides the counter width used by every debounce cell.
package key_conditioner_pkg;

    localparam int DEBOUNCE_50MHZ_20MS = 1_000_000;
    localparam int DEBOUNCE_SIM        = 4;
    localparam int NKEYS_DE1           = 4;

    // Width big enough to hold DEBOUNCE_CYCLES itself (clamped to 1 bit minimum).
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One push-button: two-flop synchroniser, stability counter, debounced level
// and one-cycle press/release pulses, all registered.
module key_debounce_cell
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic clock_50,
    input  logic reset_n,
    input  logic key,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             p;

    // Raw key is active-low; p is the synchronised "pressed" value.
    assign p       = ~sync2;
    assign pressed = stable;

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            stable        <= 1'b0;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= key;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (p == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Change has held long enough: accept it and emit one pulse.
                stable        <= p;
                cnt           <= '0;
                press_pulse   <= p;
                release_pulse <= ~p;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low DE1-SoC push-buttons into clean active-high
// levels and press/release pulses, one independent cell per key.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int NKEYS           = NKEYS_DE1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS
) (
    input  logic             clock_50,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] key,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release
);

    for (genvar i = 0; i < NKEYS; i++) begin : g_cell
        key_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clock_50      (clock_50),
            .reset_n       (reset_n),
            .key           (key[i]),
            .pressed       (key_level[i]),
            .press_pulse   (key_press[i]),
            .release_pulse (key_release[i])
        );
    end

endmodule
